// File: rtl/umips_rf_write_arbiter_if.sv
// Register-file write-port arbiter bundle: writeback, muldiv, debug and
// the shared register file write port.
interface umips_rf_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_valid;
  logic        md_ready;
  logic [31:0] md_lo;
  logic [31:0] md_hi;
  logic        md_busy;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic        proto_err;

  modport master (
    output wb_we, wb_addr, wb_data,
    output md_valid, md_lo, md_hi,
    output dbg_valid, dbg_addr, dbg_data,
    input  wb_stall, md_ready, md_busy,
    input  dbg_ready, proto_err,
    input  rf_we, rf_addr, rf_wd
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  md_valid, md_lo, md_hi,
    input  dbg_valid, dbg_addr, dbg_data,
    output wb_stall, md_ready, md_busy,
    output dbg_ready, proto_err,
    output rf_we, rf_addr, rf_wd
  );
endinterface

// File: rtl/umips_rf_write_arbiter.sv
// Shares the GPR write port between writeback, the muldiv unit (LO then HI)
// and the debug port, with a starvation stall on writeback.
module umips_rf_write_arbiter #(
  parameter logic [4:0]  MD_LO_ADDR   = 5'd8,
  parameter logic [4:0]  MD_HI_ADDR   = 5'd9,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                     clk,
  input logic                     rst,
  umips_rf_write_arbiter_if.slave arb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MD_LO = 2'd1,
    MD_HI = 2'd2
  } state_t;

  localparam logic [4:0] LIMIT5 = 5'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_lo_buf;
  logic [31:0] r_hi_buf;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;
  logic        r_wb_stall;
  logic        w_wb_stall_nxt;
  logic        r_proto_err;

  logic        w_md_pend;
  logic        w_md_win;
  logic        w_wb_win;
  logic        w_dbg_win;
  logic        w_accept;
  logic        w_starve_hit;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_wd;
  logic        w_rf_we;

  assign w_md_pend = (r_state != IDLE);

  // A stalled writeback cannot win, so md owns the port.
  assign w_md_win  = rst & w_md_pend
                   & (r_wb_stall | ~arb.wb_we);
  assign w_wb_win  = rst & ~w_md_win
                   & arb.wb_we & ~r_wb_stall;
  assign w_dbg_win = rst & ~w_md_pend
                   & ~arb.wb_we & arb.dbg_valid;
  assign w_accept  = rst & ~w_md_pend
                   & arb.md_valid;

  always_comb begin
    w_we   = 1'b0;
    w_addr = '0;
    w_wd   = '0;
    unique case (1'b1)
      w_md_win: begin
        w_we = 1'b1;
        if (r_state == MD_HI) begin
          w_addr = MD_HI_ADDR;
          w_wd   = r_hi_buf;
        end else begin
          w_addr = MD_LO_ADDR;
          w_wd   = r_lo_buf;
        end
      end
      w_wb_win: begin
        w_we   = 1'b1;
        w_addr = arb.wb_addr;
        w_wd   = arb.wb_data;
      end
      w_dbg_win: begin
        w_we   = 1'b1;
        w_addr = arb.dbg_addr;
        w_wd   = arb.dbg_data;
      end
      default: ;
    endcase
  end

  // r0 writes are consumed but never reach the register file.
  assign w_rf_we     = w_we & (w_addr != 5'd0);
  assign arb.rf_we   = w_rf_we;
  assign arb.rf_addr = w_rf_we ? w_addr : 5'd0;
  assign arb.rf_wd   = w_rf_we ? w_wd : 32'd0;

  assign arb.md_ready  = rst & ~w_md_pend;
  assign arb.dbg_ready = w_dbg_win;
  assign arb.md_busy   = w_md_pend;
  assign arb.wb_stall  = r_wb_stall;
  assign arb.proto_err = r_proto_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = MD_LO;
      MD_LO:   if (w_md_win) w_state_nxt = MD_HI;
      MD_HI:   if (w_md_win) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    w_starve_hit = 1'b0;
    if (!w_md_pend || w_md_win) begin
      w_starve_nxt = 4'd0;
    end else if (w_wb_win) begin
      if (r_starve_cnt != 4'hF)
        w_starve_nxt = r_starve_cnt + 4'd1;
      w_starve_hit =
        ({1'b0, r_starve_cnt} + 5'd1) == LIMIT5;
    end
  end

  always_comb begin
    w_wb_stall_nxt = r_wb_stall;
    if (w_starve_hit)
      w_wb_stall_nxt = 1'b1;
    if (w_md_win && r_state == MD_HI)
      w_wb_stall_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_wb_stall   <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_wb_stall   <= w_wb_stall_nxt;
      if (arb.wb_we && r_wb_stall)
        r_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lo_buf <= arb.md_lo;
      r_hi_buf <= arb.md_hi;
    end
  end

endmodule

// File: tb/tb_umips_rf_write_arbiter.sv
// Randomized and directed bench for umips_rf_write_arbiter against a
// queue-based model of pending register writes.
module tb_umips_rf_write_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  umips_rf_write_arbiter_if bus();

  umips_rf_write_arbiter #(
    .MD_LO_ADDR   (5'd8),
    .MD_HI_ADDR   (5'd9),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t mq[$];
  bit  m_stall;
  bit  m_perr;
  int  m_starve;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic        obs_we;
  logic [4:0]  obs_addr;
  logic [31:0] obs_wd;
  logic        obs_dr;
  logic        obs_mr;
  logic        obs_busy;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.wb_we     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.md_valid  = 1'b0;
    bus.md_lo     = '0;
    bus.md_hi     = '0;
    bus.dbg_valid = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_data  = '0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model.
  task automatic step();
    bit          pend, mdw, wbw, dbw, e_we;
    wr_t         w;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    #2;
    obs_we   = bus.rf_we;
    obs_addr = bus.rf_addr;
    obs_wd   = bus.rf_wd;
    obs_dr   = bus.dbg_ready;
    obs_mr   = bus.md_ready;
    obs_busy = bus.md_busy;
    pend = (mq.size() != 0);
    mdw = 1'b0;
    wbw = 1'b0;
    dbw = 1'b0;
    w   = '0;
    if (rst) begin
      if (pend && (m_stall || !bus.wb_we)) begin
        mdw = 1'b1;
        w   = mq[0];
      end else if (bus.wb_we) begin
        wbw = 1'b1;
        w   = {bus.wb_addr, bus.wb_data};
      end else if (!pend && bus.dbg_valid) begin
        dbw = 1'b1;
        w   = {bus.dbg_addr, bus.dbg_data};
      end
    end
    e_we = (mdw || wbw || dbw) && (w.a != 5'd0);
    e_a  = e_we ? w.a : 5'd0;
    e_d  = e_we ? w.d : 32'd0;
    if (chk_en) begin
      chk("rf_we", obs_we, e_we);
      chk("rf_addr", obs_addr, e_a);
      chk("rf_wd", obs_wd, e_d);
      chk("md_ready", obs_mr, rst && !pend);
      chk("dbg_ready", obs_dr, dbw);
      chk("md_busy", obs_busy, pend);
      chk("wb_stall", bus.wb_stall, m_stall);
      chk("proto_err", bus.proto_err, m_perr);
    end
    if (!rst) begin
      mq.delete();
      m_stall  = 1'b0;
      m_starve = 0;
      m_perr   = 1'b0;
    end else begin
      if (bus.wb_we && m_stall)
        m_perr = 1'b1;
      if (!pend || mdw) begin
        m_starve = 0;
      end else if (wbw) begin
        m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        if (m_starve == LIMIT)
          m_stall = 1'b1;
      end
      if (mdw) begin
        void'(mq.pop_front());
        if (mq.size() == 0)
          m_stall = 1'b0;
      end
      if (!pend && bus.md_valid) begin
        mq.push_back({5'd8, bus.md_lo});
        mq.push_back({5'd9, bus.md_hi});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic accept_md(input logic [31:0] lo,
                           input logic [31:0] hi);
    bus.md_valid = 1'b1;
    bus.md_lo    = lo;
    bus.md_hi    = hi;
    step();
    bus.md_valid = 1'b0;
  endtask

  task automatic starve_wb(output int nwb);
    nwb = 0;
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd4;
    for (int i = 0; i < 12 && !m_stall; i++) begin
      bus.wb_data = $urandom;
      step();
      if (obs_we && obs_addr == 5'd4)
        nwb++;
    end
  endtask

  initial begin
    int nwb;
    idle_in();
    rst = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rst_md_ready", obs_mr, 1);
    chk("rst_rf_we", obs_we, 0);

    // md alone
    accept_md(32'h1111_0000, 32'h2222_0000);
    step();
    chk("lo_addr", obs_addr, 8);
    chk("lo_data", obs_wd, 32'h1111_0000);
    step();
    chk("hi_addr", obs_addr, 9);
    chk("hi_data", obs_wd, 32'h2222_0000);
    step();
    chk("md_ready_back", obs_mr, 1);
    chk("md_busy_clr", obs_busy, 0);

    // priority: wb beats md, dbg waits for md to drain
    accept_md(32'hAAAA_0001, 32'hBBBB_0002);
    bus.wb_we     = 1'b1;
    bus.wb_addr   = 5'd3;
    bus.wb_data   = 32'hA5;
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = 5'd5;
    bus.dbg_data  = 32'h77;
    step();
    chk("prio_wb_addr", obs_addr, 3);
    chk("prio_wb_data", obs_wd, 32'hA5);
    bus.wb_we = 1'b0;
    step();
    chk("prio_lo_addr", obs_addr, 8);
    step();
    chk("prio_hi_addr", obs_addr, 9);
    chk("prio_dbg_wait", obs_dr, 0);
    step();
    chk("prio_dbg_rdy", obs_dr, 1);
    chk("prio_dbg_addr", obs_addr, 5);
    idle_in();

    // starvation
    accept_md(32'hC0DE_0001, 32'hC0DE_0002);
    starve_wb(nwb);
    chk("starve_nwb", nwb, LIMIT);
    chk("starve_stall", bus.wb_stall, 1);
    bus.wb_we = 1'b0;
    step();
    chk("starve_lo", obs_addr, 8);
    step();
    chk("starve_hi", obs_addr, 9);
    chk("starve_unstall", bus.wb_stall, 0);
    chk("starve_perr", bus.proto_err, 0);

    // protocol violation while stalled
    accept_md(32'hD00D_0001, 32'hD00D_0002);
    starve_wb(nwb);
    bus.wb_addr = 5'd6;
    step();
    chk("perr_md_wins", obs_addr, 8);
    chk("perr_set", bus.proto_err, 1);
    idle_in();
    step();
    step();
    chk("perr_sticky", bus.proto_err, 1);

    // debug write to r0
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = 5'd0;
    bus.dbg_data  = 32'hFFFF;
    step();
    chk("dbg0_ready", obs_dr, 1);
    chk("dbg0_we", obs_we, 0);
    idle_in();

    // reset in MD_HI
    accept_md(32'hE000_0001, 32'hE000_0002);
    step();
    rst = 1'b0;
    step();
    chk("rstmid_we", obs_we, 0);
    rst = 1'b1;
    step();
    chk("rstmid_busy", obs_busy, 0);
    chk("rstmid_we2", obs_we, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom % 100) != 0;
      bus.wb_we     = m_stall ? (($urandom % 20) == 0)
                              : (($urandom % 2) == 0);
      bus.wb_addr   = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
      bus.wb_data   = $urandom;
      bus.md_valid  = ($urandom % 3) == 0;
      bus.md_lo     = $urandom;
      bus.md_hi     = $urandom;
      bus.dbg_valid = ($urandom % 2) == 0;
      bus.dbg_addr  = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
      bus.dbg_data  = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
